// File: rtl/regfile_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_writeback: register-file write port arbiter and pending tracker. |
// | Port A wins the write port; port B results queue in a small FIFO.        |
// | Optional feature macro: WB_BYPASS_EN (write-port bypass outputs).        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_writeback #(
  parameter int XLEN       = 32,
  parameter int AREG       = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          a_valid,
  input  logic [AREG-1:0]               a_rd,
  input  logic [XLEN-1:0]               a_data,
  input  logic                          b_valid,
  output logic                          b_ready,
  input  logic [AREG-1:0]               b_rd,
  input  logic [XLEN-1:0]               b_data,
  input  logic                          iss_valid,
  input  logic [AREG-1:0]               iss_rd,
  input  logic [AREG-1:0]               chk_rs1,
  input  logic [AREG-1:0]               chk_rs2,
  output logic                          busy1,
  output logic                          busy2,
  output logic                          fwd1_hit,
  output logic [XLEN-1:0]               fwd1_data,
  output logic                          fwd2_hit,
  output logic [XLEN-1:0]               fwd2_data,
  output logic                          we,
  output logic [AREG-1:0]               WriteAddr,
  output logic [XLEN-1:0]               WriteData,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
  output logic                          err
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 2 ** AREG;

  logic [AREG-1:0] fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  logic            full;
  logic            empty;
  logic            a_take;
  logic            b_push;
  logic            pop;
  logic            iss_set;
  logic            wb_from_b;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pending_nxt;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign b_ready  = rst_n & ~full;
  assign a_take   = a_valid & (a_rd != '0);
  // x0 beats complete the handshake but never occupy a FIFO slot.
  assign b_push   = b_valid & b_ready & (b_rd != '0);
  assign pop      = ~a_take & ~empty;
  assign iss_set  = iss_valid & (iss_rd != '0);
  assign fifo_cnt = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (b_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({b_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (b_push) begin
      fifo_rd[wr_ptr]   <= b_rd;
      fifo_data[wr_ptr] <= b_data;
    end
  end

  // Write-port register; wb_from_b remembers whether the held write retires a B result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we        <= 1'b0;
      WriteAddr <= '0;
      WriteData <= '0;
      wb_from_b <= 1'b0;
    end else if (a_take) begin
      we        <= 1'b1;
      WriteAddr <= a_rd;
      WriteData <= a_data;
      wb_from_b <= 1'b0;
    end else if (pop) begin
      we        <= 1'b1;
      WriteAddr <= fifo_rd[rd_ptr];
      WriteData <= fifo_data[rd_ptr];
      wb_from_b <= 1'b1;
    end else begin
      we        <= 1'b0;
      wb_from_b <= 1'b0;
    end
  end

  // A B result stops being pending once the register file has committed it; a new issue wins.
  always_comb begin
    pending_nxt = pending;
    if (we && wb_from_b) pending_nxt[WriteAddr] = 1'b0;
    if (iss_set)         pending_nxt[iss_rd]    = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      err     <= 1'b0;
    end else begin
      pending <= pending_nxt;
      err     <= err | (iss_set & pending[iss_rd]);
    end
  end

  assign busy1 = (chk_rs1 != '0) & pending[chk_rs1];
  assign busy2 = (chk_rs2 != '0) & pending[chk_rs2];

`ifdef WB_BYPASS_EN
  assign fwd1_hit  = we & (WriteAddr == chk_rs1) & (chk_rs1 != '0);
  assign fwd1_data = WriteData;
  assign fwd2_hit  = we & (WriteAddr == chk_rs2) & (chk_rs2 != '0);
  assign fwd2_data = WriteData;
`else
  assign fwd1_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_hit  = 1'b0;
  assign fwd2_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// Randomized scoreboard bench for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
  localparam int XLEN  = 32;
  localparam int AREG  = 5;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_valid, b_valid, iss_valid;
  logic [AREG-1:0] a_rd, b_rd, iss_rd, chk_rs1, chk_rs2;
  logic [XLEN-1:0] a_data, b_data;
  logic            b_ready, busy1, busy2, fwd1_hit, fwd2_hit, we, err;
  logic [XLEN-1:0] fwd1_data, fwd2_data, WriteData;
  logic [AREG-1:0] WriteAddr;
  logic [$clog2(DEPTH):0] fifo_cnt;

  regfile_writeback #(.XLEN(XLEN), .AREG(AREG), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2),
    .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data), .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
    .we(we), .WriteAddr(WriteAddr), .WriteData(WriteData),
    .fifo_cnt(fifo_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic we; logic [AREG-1:0] addr; logic [XLEN-1:0] data; } wr_t;
  typedef struct { logic [AREG-1:0] rd; logic [XLEN-1:0] data; } ent_t;

  wr_t  sb[$];
  ent_t mq[$];
  logic [31:0]     pend;
  logic            m_err;
  logic            cur_we, cur_fromb;
  logic [AREG-1:0] cur_addr;
  logic [XLEN-1:0] cur_data;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    mq.delete();
    pend      = '0;
    m_err     = 1'b0;
    cur_we    = 1'b0;
    cur_fromb = 1'b0;
    cur_addr  = '0;
    cur_data  = '0;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_rd = 0; a_data = 0;
    b_valid = 0; b_rd = 0; b_data = 0;
    iss_valid = 0; iss_rd = 0; chk_rs1 = 0; chk_rs2 = 0;
  endtask

  // Write-port monitor: each cycle's expected write-port contents are compared as they appear.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("we", 64'(we), 64'(e.we));
      if (e.we) begin
        chk("WriteAddr", 64'(WriteAddr), 64'(e.addr));
        chk("WriteData", 64'(WriteData), 64'(e.data));
      end
    end
  end

  task automatic cycle(input logic av, input logic [AREG-1:0] ard, input logic [XLEN-1:0] ad,
                       input logic bv, input logic [AREG-1:0] brd, input logic [XLEN-1:0] bd,
                       input logic iv, input logic [AREG-1:0] ird,
                       input logic [AREG-1:0] c1, input logic [AREG-1:0] c2);
    wr_t  w;
    ent_t e;
    logic exp_br, fb, h1, h2;
    @(negedge clk); #1;
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    iss_valid = iv; iss_rd = ird; chk_rs1 = c1; chk_rs2 = c2;
    #1;
    exp_br = (mq.size() < DEPTH);
    chk("b_ready", 64'(b_ready), 64'(exp_br));
    chk("fifo_cnt", 64'(fifo_cnt), 64'(mq.size()));
    chk("busy1", 64'(busy1), 64'((c1 != 0) && pend[c1]));
    chk("busy2", 64'(busy2), 64'((c2 != 0) && pend[c2]));
    chk("err", 64'(err), 64'(m_err));
`ifdef WB_BYPASS_EN
    h1 = cur_we && (cur_addr == c1) && (c1 != 0);
    h2 = cur_we && (cur_addr == c2) && (c2 != 0);
    chk("fwd1_hit", 64'(fwd1_hit), 64'(h1));
    chk("fwd2_hit", 64'(fwd2_hit), 64'(h2));
    if (h1) chk("fwd1_data", 64'(fwd1_data), 64'(cur_data));
    if (h2) chk("fwd2_data", 64'(fwd2_data), 64'(cur_data));
`else
    h1 = 1'b0;
    h2 = 1'b0;
    chk("fwd1_hit", 64'(fwd1_hit), 64'(h1));
    chk("fwd2_hit", 64'(fwd2_hit), 64'(h2));
    chk("fwd1_data", 64'(fwd1_data), 64'(0));
    chk("fwd2_data", 64'(fwd2_data), 64'(0));
`endif
    // Reference behaviour of the coming edge.
    w  = '{we: 1'b0, addr: '0, data: '0};
    fb = 1'b0;
    if (av && ard != 0) begin
      w = '{we: 1'b1, addr: ard, data: ad};
    end else if (mq.size() > 0) begin
      e  = mq.pop_front();
      w  = '{we: 1'b1, addr: e.rd, data: e.data};
      fb = 1'b1;
    end
    if (bv && exp_br && brd != 0) mq.push_back('{rd: brd, data: bd});
    if (iv && ird != 0 && pend[ird]) m_err = 1'b1;
    if (cur_we && cur_fromb) pend[cur_addr] = 1'b0;
    if (iv && ird != 0) pend[ird] = 1'b1;
    cur_we = w.we; cur_addr = w.addr; cur_data = w.data; cur_fromb = fb;
    sb.push_back(w);
  endtask

  task automatic idle(input logic [AREG-1:0] c1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset we", 64'(we), 64'(0));
    chk("reset WriteAddr", 64'(WriteAddr), 64'(0));
    chk("reset WriteData", 64'(WriteData), 64'(0));
    chk("reset fifo_cnt", 64'(fifo_cnt), 64'(0));
    chk("reset b_ready", 64'(b_ready), 64'(0));
    chk("reset err", 64'(err), 64'(0));
    rst_n = 1'b1;

    // A only
    cycle(1, 3, 32'h11, 0, 0, 0, 0, 0, 3, 0);
    idle(3); idle(3);
    // A/B collision
    cycle(1, 4, 32'hA, 1, 5, 32'hB, 0, 0, 4, 5);
    idle(5); idle(5);
    // FIFO full while A holds the port
    cycle(1, 1, 32'h101, 1, 11, 32'h211, 0, 0, 0, 0);
    cycle(1, 2, 32'h102, 1, 12, 32'h212, 0, 0, 0, 0);
    cycle(1, 3, 32'h103, 1, 13, 32'h213, 0, 0, 0, 0);
    cycle(1, 4, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    idle(0); idle(0); idle(0);
    // Scoreboard: set, clear after retirement, set-wins, re-issue error
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cycle(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0);
    idle(7); idle(7); idle(7);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    cycle(0, 0, 0, 1, 7, 32'h78, 0, 0, 7, 0);
    idle(7);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7);
    cycle(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7);
    // x0 on both ports
    cycle(1, 2, 32'h22, 1, 6, 32'h66, 0, 0, 0, 0);
    cycle(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 0);
    idle(0); idle(0);
    // Asynchronous reset mid-run
    cycle(1, 1, 32'h1, 1, 9, 32'h9, 1, 9, 9, 10);
    cycle(1, 2, 32'h2, 1, 10, 32'hA, 1, 10, 9, 10);
    cycle(1, 3, 32'h3, 0, 0, 0, 0, 0, 9, 10);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async we", 64'(we), 64'(0));
    chk("async fifo_cnt", 64'(fifo_cnt), 64'(0));
    chk("async busy1", 64'(busy1), 64'(0));
    chk("async busy2", 64'(busy2), 64'(0));
    chk("async b_ready", 64'(b_ready), 64'(0));
    chk("async err", 64'(err), 64'(0));
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic on a small register range to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 2) == 0), AREG'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 1) == 1), AREG'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 5) == 0), AREG'($urandom_range(0, 7)),
            AREG'($urandom_range(0, 7)), AREG'($urandom_range(0, 7)));
    end
    repeat (4) idle(0);
    @(negedge clk);
    #1;
    chk("scoreboard drained", 64'(sb.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
